// File: rtl/triangle_traverser_pkg.sv
// Shared types, widths and arithmetic helpers for the triangle traverser.
// The edge coefficients and the inside test live here so that every user computes them the same way.
package triangle_traverser_pkg;

  localparam int COORD_W       = 16;
  localparam int EDGE_W        = 32;
  localparam int DEF_FRAC_BITS = 8;
  localparam int DEF_SCREEN_W  = 64;
  localparam int DEF_SCREEN_H  = 64;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT,
    EMIT,
    DONE
  } state_t;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [EDGE_W-1:0]  edge_t;

  // Two's complement difference that wraps at COORD_W bits.
  function automatic coord_t edge_coef(input coord_t minuend, input coord_t subtrahend);
    return minuend - subtrahend;
  endfunction

  // A pixel on an edge counts as inside for either winding.
  function automatic logic is_inside(input edge_t e1, input edge_t e2, input edge_t e3);
    logic nonneg;
    logic nonpos;
    nonneg = !e1[EDGE_W-1] && !e2[EDGE_W-1] && !e3[EDGE_W-1];
    nonpos = (e1[EDGE_W-1] || (e1 == '0)) &&
             (e2[EDGE_W-1] || (e2 == '0)) &&
             (e3[EDGE_W-1] || (e3 == '0));
    return nonneg || nonpos;
  endfunction

endpackage

// File: rtl/triangle_traverser_bbox.sv
// Combinational bounding box: min/max of three vertices, floor to pixel index,
// clamp to the screen, and flag a box that lies entirely off screen.
module tri_bbox
  import triangle_traverser_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic signed [COORD_W-1:0] v0x,
  input  logic signed [COORD_W-1:0] v0y,
  input  logic signed [COORD_W-1:0] v1x,
  input  logic signed [COORD_W-1:0] v1y,
  input  logic signed [COORD_W-1:0] v2x,
  input  logic signed [COORD_W-1:0] v2y,
  output logic        [COORD_W-1:0] xmin,
  output logic        [COORD_W-1:0] xmax,
  output logic        [COORD_W-1:0] ymin,
  output logic        [COORD_W-1:0] ymax,
  output logic                      empty
);

  localparam coord_t X_LIM = COORD_W'(SCREEN_W - 1);
  localparam coord_t Y_LIM = COORD_W'(SCREEN_H - 1);

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] clamp(input coord_t v, input coord_t lim);
    if (v[COORD_W-1]) return '0;
    if (v > lim)      return $unsigned(lim);
    return $unsigned(v);
  endfunction

  coord_t raw_xmin, raw_xmax, raw_ymin, raw_ymax;

  // Arithmetic shift floors toward minus infinity, which is what a pixel index needs.
  always_comb begin
    raw_xmin = min3(v0x, v1x, v2x) >>> FRAC_BITS;
    raw_xmax = max3(v0x, v1x, v2x) >>> FRAC_BITS;
    raw_ymin = min3(v0y, v1y, v2y) >>> FRAC_BITS;
    raw_ymax = max3(v0y, v1y, v2y) >>> FRAC_BITS;
    xmin     = clamp(raw_xmin, X_LIM);
    xmax     = clamp(raw_xmax, X_LIM);
    ymin     = clamp(raw_ymin, Y_LIM);
    ymax     = clamp(raw_ymax, Y_LIM);
    empty    = raw_xmax[COORD_W-1] || raw_ymax[COORD_W-1] ||
               (raw_xmin > X_LIM) || (raw_ymin > Y_LIM);
  end

endmodule

// File: rtl/triangle_traverser.sv
// Rasterizer front end: accepts a triangle, sets up edges and bounding box,
// then walks the box in raster order using an external edge-function unit.
module triangle_traverser
  import triangle_traverser_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  input  logic signed [COORD_W-1:0] v0x,
  input  logic signed [COORD_W-1:0] v0y,
  input  logic signed [COORD_W-1:0] v1x,
  input  logic signed [COORD_W-1:0] v1y,
  input  logic signed [COORD_W-1:0] v2x,
  input  logic signed [COORD_W-1:0] v2y,
  output logic                      valid_data,
  output logic signed [COORD_W-1:0] px,
  output logic signed [COORD_W-1:0] py,
  output logic signed [COORD_W-1:0] ev0x,
  output logic signed [COORD_W-1:0] ev0y,
  output logic signed [COORD_W-1:0] ev1x,
  output logic signed [COORD_W-1:0] ev1y,
  output logic signed [COORD_W-1:0] ev2x,
  output logic signed [COORD_W-1:0] ev2y,
  output logic signed [COORD_W-1:0] a1,
  output logic signed [COORD_W-1:0] a2,
  output logic signed [COORD_W-1:0] a3,
  output logic signed [COORD_W-1:0] b1,
  output logic signed [COORD_W-1:0] b2,
  output logic signed [COORD_W-1:0] b3,
  input  logic signed [EDGE_W-1:0]  e1,
  input  logic signed [EDGE_W-1:0]  e2,
  input  logic signed [EDGE_W-1:0]  e3,
  input  logic                      edge_done,
  output logic                      pix_valid,
  output logic        [COORD_W-1:0] pix_x,
  output logic        [COORD_W-1:0] pix_y,
  input  logic                      pix_ready,
  output logic                      tri_done
);

  state_t state_q, state_d;
  coord_t ev0x_q, ev0y_q, ev1x_q, ev1y_q, ev2x_q, ev2y_q;
  coord_t ev0x_d, ev0y_d, ev1x_d, ev1y_d, ev2x_d, ev2y_d;
  coord_t a1_q, a2_q, a3_q, b1_q, b2_q, b3_q;
  coord_t a1_d, a2_d, a3_d, b1_d, b2_d, b3_d;
  logic [COORD_W-1:0] x_q, y_q, x_d, y_d;

  logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic               bb_empty;

  // Box is derived from the captured vertices, which hold still for the whole traversal.
  tri_bbox #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .FRAC_BITS(FRAC_BITS)
  ) u_bbox (
    .v0x  (ev0x_q),
    .v0y  (ev0y_q),
    .v1x  (ev1x_q),
    .v1y  (ev1y_q),
    .v2x  (ev2x_q),
    .v2y  (ev2y_q),
    .xmin (bb_xmin),
    .xmax (bb_xmax),
    .ymin (bb_ymin),
    .ymax (bb_ymax),
    .empty(bb_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ev0x_q  <= '0;
      ev0y_q  <= '0;
      ev1x_q  <= '0;
      ev1y_q  <= '0;
      ev2x_q  <= '0;
      ev2y_q  <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      b3_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ev0x_q  <= ev0x_d;
      ev0y_q  <= ev0y_d;
      ev1x_q  <= ev1x_d;
      ev1y_q  <= ev1y_d;
      ev2x_q  <= ev2x_d;
      ev2y_q  <= ev2y_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      a3_q    <= a3_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      b3_q    <= b3_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  state_t             adv_state;
  logic [COORD_W-1:0] adv_x, adv_y;

  always_comb begin
    adv_state = ISSUE;
    adv_x     = x_q;
    adv_y     = y_q;
    if (x_q < bb_xmax) begin
      adv_x = x_q + COORD_W'(1);
    end else if (y_q < bb_ymax) begin
      adv_x = bb_xmin;
      adv_y = y_q + COORD_W'(1);
    end else begin
      adv_state = DONE;
    end
  end

  always_comb begin
    state_d = state_q;
    ev0x_d  = ev0x_q;
    ev0y_d  = ev0y_q;
    ev1x_d  = ev1x_q;
    ev1y_d  = ev1y_q;
    ev2x_d  = ev2x_q;
    ev2y_d  = ev2y_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    b3_d    = b3_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (tri_valid) begin
          ev0x_d  = v0x;
          ev0y_d  = v0y;
          ev1x_d  = v1x;
          ev1y_d  = v1y;
          ev2x_d  = v2x;
          ev2y_d  = v2y;
          state_d = SETUP;
        end
      end
      SETUP: begin
        a1_d = edge_coef(ev1y_q, ev0y_q);
        b1_d = edge_coef(ev0x_q, ev1x_q);
        a2_d = edge_coef(ev2y_q, ev1y_q);
        b2_d = edge_coef(ev1x_q, ev2x_q);
        a3_d = edge_coef(ev0y_q, ev2y_q);
        b3_d = edge_coef(ev2x_q, ev0x_q);
        if (bb_empty) begin
          state_d = DONE;
        end else begin
          x_d     = bb_xmin;
          y_d     = bb_ymin;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (edge_done) begin
          if (is_inside(e1, e2, e3)) begin
            state_d = EMIT;
          end else begin
            state_d = adv_state;
            x_d     = adv_x;
            y_d     = adv_y;
          end
        end
      end
      EMIT: begin
        if (pix_ready) begin
          state_d = adv_state;
          x_d     = adv_x;
          y_d     = adv_y;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tri_ready  = (state_q == IDLE);
  assign valid_data = (state_q == ISSUE);
  assign pix_valid  = (state_q == EMIT);
  assign tri_done   = (state_q == DONE);
  assign px         = $signed(x_q << FRAC_BITS);
  assign py         = $signed(y_q << FRAC_BITS);
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign ev0x       = ev0x_q;
  assign ev0y       = ev0y_q;
  assign ev1x       = ev1x_q;
  assign ev1y       = ev1y_q;
  assign ev2x       = ev2x_q;
  assign ev2y       = ev2y_q;
  assign a1         = a1_q;
  assign a2         = a2_q;
  assign a3         = a3_q;
  assign b1         = b1_q;
  assign b2         = b2_q;
  assign b3         = b3_q;

endmodule

// File: tb/tb_triangle_traverser.sv
// Bench for triangle_traverser: an edge-function unit with random latency, a random
// downstream ready, and a pixel-list model of the expected coverage in raster order.
module tb_triangle_traverser;

  logic clk;
  logic rst;
  logic tri_valid, tri_ready;
  logic signed [15:0] v0x, v0y, v1x, v1y, v2x, v2y;
  logic valid_data;
  logic signed [15:0] px, py;
  logic signed [15:0] ev0x, ev0y, ev1x, ev1y, ev2x, ev2y;
  logic signed [15:0] a1, a2, a3, b1, b2, b3;
  logic signed [31:0] e1, e2, e3;
  logic edge_done;
  logic pix_valid;
  logic [15:0] pix_x, pix_y;
  logic pix_ready;
  logic tri_done;

  triangle_traverser dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .valid_data(valid_data), .px(px), .py(py),
    .ev0x(ev0x), .ev0y(ev0y), .ev1x(ev1x), .ev1y(ev1y), .ev2x(ev2x), .ev2y(ev2y),
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
    .e1(e1), .e2(e2), .e3(e3), .edge_done(edge_done),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_ready(pix_ready),
    .tri_done(tri_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int x; int y;} pix_t;
  pix_t exp_q[$];
  int   exp_evals, exp_npix;
  int   m_v[6];
  int   m_a[3], m_b[3];

  function automatic int floor256(input int v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int min3i(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int max3i(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  task automatic build_model(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2);
    int xlo, xhi, ylo, yhi, ea, eb, ec;
    m_v[0] = x0; m_v[1] = y0; m_v[2] = x1; m_v[3] = y1; m_v[4] = x2; m_v[5] = y2;
    m_a[0] = y1 - y0; m_b[0] = x0 - x1;
    m_a[1] = y2 - y1; m_b[1] = x1 - x2;
    m_a[2] = y0 - y2; m_b[2] = x2 - x0;
    exp_q.delete();
    exp_evals = 0;
    exp_npix  = 0;
    xlo = floor256(min3i(x0, x1, x2));
    xhi = floor256(max3i(x0, x1, x2));
    ylo = floor256(min3i(y0, y1, y2));
    yhi = floor256(max3i(y0, y1, y2));
    if (xhi < 0 || yhi < 0 || xlo > 63 || ylo > 63) return;
    if (xlo < 0) xlo = 0;
    if (ylo < 0) ylo = 0;
    if (xhi > 63) xhi = 63;
    if (yhi > 63) yhi = 63;
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        exp_evals++;
        ea = m_a[0] * (x * 256 - x0) + m_b[0] * (y * 256 - y0);
        eb = m_a[1] * (x * 256 - x1) + m_b[1] * (y * 256 - y1);
        ec = m_a[2] * (x * 256 - x2) + m_b[2] * (y * 256 - y2);
        if ((ea >= 0 && eb >= 0 && ec >= 0) || (ea <= 0 && eb <= 0 && ec <= 0)) begin
          pix_t p;
          p.x = x;
          p.y = y;
          exp_q.push_back(p);
          exp_npix++;
        end
      end
    end
  endtask

  // ---------------- environment state ----------------
  bit pending    = 0;
  int lat_cnt    = 0;
  int r1, r2, r3;
  bit edge_en    = 1;
  bit stale_req  = 0;
  int ready_mode = 0;
  int stall_used = 0;
  bit prev_stall = 0;
  logic [15:0] held_x, held_y;
  int eval_cnt = 0, pix_cnt = 0, done_cnt = 0;
  int eval0, pix0, done0;

  // Per-cycle edge unit, downstream ready and output comparison, all at the falling edge.
  task automatic tick();
    pix_t p;
    edge_done = 1'b0;
    if (rst) begin
      pending = 0;
    end else if (stale_req) begin
      edge_done = 1'b1;
      e1 = -1; e2 = -1; e3 = -1;
      stale_req = 0;
    end else if (valid_data) begin
      check("single_outstanding", int'(pending), 0);
      pending = 1;
      lat_cnt = int'($urandom_range(0, 3));
      eval_cnt++;
      r1 = int'(a1) * (int'(px) - int'(ev0x)) + int'(b1) * (int'(py) - int'(ev0y));
      r2 = int'(a2) * (int'(px) - int'(ev1x)) + int'(b2) * (int'(py) - int'(ev1y));
      r3 = int'(a3) * (int'(px) - int'(ev2x)) + int'(b3) * (int'(py) - int'(ev2y));
    end else if (pending && edge_en) begin
      if (lat_cnt == 0) begin
        edge_done = 1'b1;
        e1 = r1; e2 = r2; e3 = r3;
        pending = 0;
      end else begin
        lat_cnt--;
      end
    end

    if (ready_mode == 1) begin
      if (pix_valid && stall_used < 5) begin
        pix_ready = 1'b0;
        stall_used++;
      end else begin
        pix_ready = 1'b1;
      end
    end else begin
      pix_ready = ($urandom_range(0, 3) != 0);
    end

    if (prev_stall) begin
      check("stall_valid", int'(pix_valid), 1);
      check("stall_x", int'(pix_x), int'(held_x));
      check("stall_y", int'(pix_y), int'(held_y));
    end
    if (pix_valid) check("no_issue_in_emit", int'(valid_data), 0);
    if (pix_valid && pix_ready) begin
      pix_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_pixel: got (%0d,%0d), expected none", pix_x, pix_y);
      end else begin
        p = exp_q.pop_front();
        check("pix_x", int'(pix_x), p.x);
        check("pix_y", int'(pix_y), p.y);
      end
    end
    prev_stall = pix_valid && !pix_ready;
    held_x     = pix_x;
    held_y     = pix_y;
    if (tri_done) done_cnt++;
  endtask

  task automatic step();
    @(negedge clk);
    tick();
  endtask

  task automatic start_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
    int k;
    build_model(x0, y0, x1, y1, x2, y2);
    eval0 = eval_cnt;
    pix0  = pix_cnt;
    done0 = done_cnt;
    step();
    check("tri_ready_idle", int'(tri_ready), 1);
    v0x = 16'(x0); v0y = 16'(y0);
    v1x = 16'(x1); v1y = 16'(y1);
    v2x = 16'(x2); v2y = 16'(y2);
    tri_valid = 1'b1;
    step();
    tri_valid = 1'b0;
    k = 1;
    while (!valid_data && !tri_done && k < 10) begin
      step();
      k++;
    end
    check("first_event_latency", k, 2);
  endtask

  task automatic finish_tri();
    int n;
    n = 0;
    while (done_cnt == done0 && n < 20000) begin
      step();
      n++;
    end
    check("tri_done_seen", done_cnt - done0, 1);
    check("evals", eval_cnt - eval0, exp_evals);
    check("pixels", pix_cnt - pix0, exp_npix);
    check("queue_empty", exp_q.size(), 0);
    step();
    check("tri_done_pulse", int'(tri_done), 0);
    check("back_to_idle", int'(tri_ready), 1);
  endtask

  task automatic check_coefs();
    check("a1", int'(a1), m_a[0]);
    check("b1", int'(b1), m_b[0]);
    check("a2", int'(a2), m_a[1]);
    check("b2", int'(b2), m_b[1]);
    check("a3", int'(a3), m_a[2]);
    check("b3", int'(b3), m_b[2]);
  endtask

  initial begin
    rst = 1'b1;
    tri_valid = 1'b0;
    v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
    e1 = '0; e2 = '0; e3 = '0;
    edge_done = 1'b0;
    pix_ready = 1'b1;
    repeat (3) step();
    check("rst_tri_ready", int'(tri_ready), 1);
    check("rst_valid_data", int'(valid_data), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_tri_done", int'(tri_done), 0);
    check("rst_a1", int'(a1), 0);
    check("rst_b2", int'(b2), 0);
    check("rst_ev0x", int'(ev0x), 0);
    check("rst_px", int'(px), 0);
    rst = 1'b0;
    step();

    // Right triangle (0,0),(4,0),(0,4)
    start_tri(0, 0, 1024, 0, 0, 1024);
    check("model_evals_right", exp_evals, 25);
    check("model_pixels_right", exp_npix, 15);
    check("lit_a1", int'(a1), 0);
    check("lit_b1", int'(b1), -1024);
    check("lit_a2", int'(a2), 1024);
    check("lit_b2", int'(b2), 1024);
    check("lit_a3", int'(a3), -1024);
    check("lit_b3", int'(b3), 0);
    finish_tri();

    // Negative vertices: box clamps to [0,2]x[0,2], nothing covered
    start_tri(-768, -768, 512, -768, -768, 512);
    check("model_evals_neg", exp_evals, 9);
    check("model_pixels_neg", exp_npix, 0);
    check_coefs();
    finish_tri();

    // Entirely right of the screen: empty box
    start_tri(16384, 256, 20000, 256, 18000, 2560);
    check("model_evals_off", exp_evals, 0);
    check("done_at_two", int'(tri_done), 1);
    finish_tri();

    // Stall the first covered pixel for five cycles
    ready_mode = 1;
    stall_used = 0;
    start_tri(256, 256, 1536, 256, 256, 1536);
    finish_tri();
    check("stall_cycles", stall_used, 5);
    ready_mode = 0;

    // tri_valid during WAIT is ignored
    edge_en = 0;
    start_tri(300, 200, 2000, 700, 900, 1900);
    step();
    tri_valid = 1'b1;
    v0x = 16'(5000); v0y = 16'(4000); v1x = 16'(100); v1y = 16'(50);
    v2x = 16'(3000); v2y = 16'(7000);
    repeat (3) step();
    check("busy_not_ready", int'(tri_ready), 0);
    tri_valid = 1'b0;
    check_coefs();
    check("ev0x_hold", int'(ev0x), m_v[0]);
    check("ev2y_hold", int'(ev2y), m_v[5]);
    edge_en = 1;
    finish_tri();

    // Reset while waiting on the edge unit
    edge_en = 0;
    start_tri(100, 100, 1800, 300, 600, 1500);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_tri_ready", int'(tri_ready), 1);
    check("mid_rst_valid_data", int'(valid_data), 0);
    check("mid_rst_pix_valid", int'(pix_valid), 0);
    check("mid_rst_tri_done", int'(tri_done), 0);
    check("mid_rst_a2", int'(a2), 0);
    check("mid_rst_b3", int'(b3), 0);
    check("mid_rst_px", int'(px), 0);
    check("mid_rst_ev1x", int'(ev1x), 0);
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    edge_en = 1;
    stale_req = 1;
    step();
    step();
    check("stale_ignored_idle", int'(tri_ready), 1);
    check("stale_no_pixel", int'(pix_valid), 0);
    check("stale_no_issue", int'(valid_data), 0);
    start_tri(512, 256, 2048, 1024, 256, 2304);
    finish_tri();

    // Random triangles
    for (int t = 0; t < 6; t++) begin
      int rv[6];
      for (int i = 0; i < 6; i++) rv[i] = int'($urandom_range(0, 5120)) - 1024;
      start_tri(rv[0], rv[1], rv[2], rv[3], rv[4], rv[5]);
      check_coefs();
      finish_tri();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
